// File: rtl/conv1d_row_array.sv
// 1-D convolution row engine: KSIZE-tap weights, NOUT accumulators, stride 1/2,
// valid/ready on weights, pixels and results; finished psums queue in a small FIFO.
module conv1d_row_array #(
  parameter int WIDTH = 16,
  parameter int KSIZE = 3,
  parameter int NOUT  = 14,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      stride2,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic signed [WIDTH-1:0]   w_data,
  input  logic                      f_valid,
  output logic                      f_ready,
  input  logic signed [WIDTH-1:0]   f_data,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic signed [2*WIDTH-1:0] o_psum,
  output logic [$clog2(NOUT)-1:0]   o_idx,
  output logic                      busy,
  output logic                      done
);
  localparam int AW   = 2*WIDTH;
  localparam int LMAX = 2*(NOUT-1) + KSIZE;
  localparam int PW   = $clog2(LMAX+1);
  localparam int KW   = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int WCW  = $clog2(KSIZE+1);
  localparam int IW   = $clog2(NOUT);
  localparam int FW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;
  state_t state, state_nxt;

  logic                    stride2_q;
  logic [WCW-1:0]          w_cnt;
  logic [PW-1:0]           pix_cnt;
  logic [PW-1:0]           pix_last;
  logic signed [WIDTH-1:0] w_q  [KSIZE];
  logic signed [AW-1:0]    acc  [NOUT];
  logic signed [AW-1:0]    prod [NOUT];
  logic [NOUT-1:0]         pe_last;

  logic signed [AW-1:0]    fifo_mem [DEPTH];
  logic [IW-1:0]           fifo_idx [DEPTH];
  logic [FW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           fifo_cnt;
  logic                    fifo_full, fifo_empty;

  logic                    w_fire, f_fire, o_fire, w_last, f_last, push;
  logic signed [AW-1:0]    push_psum;
  logic [IW-1:0]           push_idx;

  // Accumulation wraps modulo 2^AW; no saturation.
  function automatic logic signed [AW-1:0] wrap_add(input logic signed [AW-1:0] a,
                                                    input logic signed [AW-1:0] b);
    return a + b;
  endfunction

  function automatic logic [FW-1:0] ptr_inc(input logic [FW-1:0] p);
    return (p == FW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign w_fire   = w_valid && w_ready;
  assign f_fire   = f_valid && f_ready;
  assign o_fire   = o_valid && o_ready;
  assign pix_last = stride2_q ? PW'(2*(NOUT-1) + KSIZE - 1) : PW'(NOUT + KSIZE - 2);
  assign w_last   = w_fire && (w_cnt == WCW'(KSIZE-1));
  assign f_last   = f_fire && (pix_cnt == pix_last);

  // Per-output tap selection: accumulator j sees pixel x when j*S <= x < j*S+KSIZE.
  for (genvar j = 0; j < NOUT; j++) begin : g_pe
    logic [PW-1:0]        base, tap;
    logic                 hit;
    logic signed [AW-1:0] wx, fx;
    assign base       = stride2_q ? PW'(2*j) : PW'(j);
    assign tap        = pix_cnt - base;
    assign hit        = (pix_cnt >= base) && (tap < PW'(KSIZE));
    assign wx         = hit ? AW'(w_q[tap[KW-1:0]]) : '0;
    assign fx         = AW'(f_data);
    assign prod[j]    = wx * fx;
    assign pe_last[j] = hit && (tap == PW'(KSIZE-1));
  end

  // Completion indices are distinct, so at most one PE finishes per pixel.
  always_comb begin
    push      = 1'b0;
    push_psum = '0;
    push_idx  = '0;
    for (int j = 0; j < NOUT; j++) begin
      if (f_fire && pe_last[j]) begin
        push      = 1'b1;
        push_psum = wrap_add(acc[j], prod[j]);
        push_idx  = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)      state_nxt = LOAD_W;
      LOAD_W:  if (w_last)     state_nxt = STREAM;
      STREAM:  if (f_last)     state_nxt = DRAIN;
      DRAIN:   if (fifo_empty) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ready = (state == LOAD_W);
    f_ready = (state == STREAM) && !fifo_full;
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stride2_q <= 1'b0;
      w_cnt     <= '0;
      pix_cnt   <= '0;
      done      <= 1'b0;
      for (int k = 0; k < KSIZE; k++) w_q[k] <= '0;
      for (int j = 0; j < NOUT; j++)  acc[j] <= '0;
    end else begin
      done <= (state == DRAIN) && fifo_empty;
      if (state == IDLE && start) begin
        stride2_q <= stride2;
        w_cnt     <= '0;
      end
      if (w_fire) begin
        w_q[w_cnt[KW-1:0]] <= w_data;
        w_cnt              <= w_last ? '0 : w_cnt + 1'b1;
        if (w_last) begin
          pix_cnt <= '0;
          for (int j = 0; j < NOUT; j++) acc[j] <= '0;
        end
      end
      if (f_fire) begin
        pix_cnt <= pix_cnt + 1'b1;
        for (int j = 0; j < NOUT; j++) acc[j] <= wrap_add(acc[j], prod[j]);
      end
    end
  end

  // Output FIFO: simultaneous push and pop both take effect.
  assign fifo_full  = (fifo_cnt == CW'(DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= '0;
        fifo_idx[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_psum;
        fifo_idx[wr_ptr] <= push_idx;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (o_fire) rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(o_fire);
    end
  end

  assign o_valid = !fifo_empty;
  assign o_psum  = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign o_idx   = fifo_empty ? '0 : fifo_idx[rd_ptr];

endmodule

// File: tb/tb_conv1d_row_array.sv
// Directed bench for conv1d_row_array: a reference convolution builds the expected
// result queue per row and a negedge monitor scores every consumed result.
module tb_conv1d_row_array;
  localparam int WIDTH = 16;
  localparam int KSIZE = 3;
  localparam int NOUT  = 14;
  localparam int DEPTH = 4;
  localparam int IW    = $clog2(NOUT);

  logic                      clk = 1'b0;
  logic                      rstn = 1'b0;
  logic                      start = 1'b0;
  logic                      stride2 = 1'b0;
  logic                      w_valid = 1'b0;
  logic                      f_valid = 1'b0;
  logic                      o_ready = 1'b1;
  logic signed [WIDTH-1:0]   w_data = '0;
  logic signed [WIDTH-1:0]   f_data = '0;
  logic                      w_ready, f_ready, o_valid, busy, done;
  logic signed [2*WIDTH-1:0] o_psum;
  logic [IW-1:0]             o_idx;

  conv1d_row_array #(.WIDTH(WIDTH), .KSIZE(KSIZE), .NOUT(NOUT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stride2(stride2),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_psum(o_psum), .o_idx(o_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic signed [WIDTH-1:0] wv [KSIZE];
  logic signed [WIDTH-1:0] fv [64];
  logic [31:0] exp_ps [$];
  int          exp_ix [$];
  logic [31:0] rx [64];
  int rx_n = 0;
  int done_cnt = 0;
  int row_d0 = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  // Reference: out[j] = sum_k w[k]*f[j*S+k], truncated to 32 bits.
  function automatic logic [31:0] ref_out(input int j, input int s);
    longint a = 0;
    for (int k = 0; k < KSIZE; k++) a += longint'(wv[k]) * longint'(fv[j*s+k]);
    return 32'(a);
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      if (o_valid && o_ready) begin
        if (exp_ps.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got psum %0h idx %0d, want none", o_psum, o_idx);
        end else begin
          check("psum", o_psum, exp_ps.pop_front());
          check("idx", 32'(o_idx), exp_ix.pop_front());
          if (rx_n < 64) rx[rx_n] = o_psum;
          rx_n++;
        end
      end else if (!o_valid) begin
        check("psum_when_empty", o_psum, 32'h0);
      end
      if (done) done_cnt++;
    end
  end

  task automatic send(input bit is_w, input logic signed [WIDTH-1:0] d);
    int n = 0;
    if (is_w) begin w_valid = 1'b1; w_data = d; end
    else      begin f_valid = 1'b1; f_data = d; end
    @(negedge clk);
    while (!(is_w ? w_ready : f_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!(is_w ? w_ready : f_ready)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL handshake_timeout: ready got 0, want 1");
    end
    @(posedge clk); #1;
    if (is_w) w_valid = 1'b0;
    else      f_valid = 1'b0;
  endtask

  task automatic send_pix(input int a, input int b);
    for (int x = a; x <= b; x++) send(1'b0, fv[x]);
  endtask

  task automatic begin_row(input bit s2, input bit start_in_load);
    int s = s2 ? 2 : 1;
    exp_ps.delete();
    exp_ix.delete();
    rx_n   = 0;
    row_d0 = done_cnt;
    for (int j = 0; j < NOUT; j++) begin
      exp_ps.push_back(ref_out(j, s));
      exp_ix.push_back(j);
    end
    stride2 = s2;
    start   = 1'b1;
    @(posedge clk); #1;
    start = start_in_load;
    check("busy_after_start", busy, 1);
    check("w_ready_after_start", w_ready, 1);
    for (int k = 0; k < KSIZE; k++) send(1'b1, wv[k]);
    start = 1'b0;
  endtask

  task automatic end_row();
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    check("busy_low_in_done", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt - row_d0, 1);
    check("result_count", rx_n, NOUT);
    check("expected_drained", exp_ps.size(), 0);
  endtask

  task automatic set_ramp();
    wv = '{16'sd1, 16'sd2, 16'sd3};
    for (int i = 0; i < 64; i++) fv[i] = 16'(i);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_w_ready", w_ready, 0);
    check("rst_f_ready", f_ready, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_psum", o_psum, 0);
    check("rst_o_idx", 32'(o_idx), 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Stride 1 ramp
    set_ramp();
    begin_row(1'b0, 1'b0);
    send_pix(0, 15);
    end_row();
    check("t1_out0", rx[0], 32'd8);
    check("t1_out1", rx[1], 32'd14);
    check("t1_out13", rx[13], 32'd86);

    // Stride 2 ramp
    begin_row(1'b1, 1'b0);
    send_pix(0, 1);
    check("t2_no_early_result", o_valid, 0);
    send_pix(2, 2);
    check("t2_first_latency", o_valid, 1);
    check("t2_first_value", o_psum, 32'd8);
    send_pix(3, 28);
    end_row();
    check("t2_out1", rx[1], 32'd20);
    check("t2_out13", rx[13], 32'd164);

    // Backpressure: FIFO fills with four results and pixel 6 is held
    o_ready = 1'b0;
    begin_row(1'b0, 1'b0);
    fork
      send_pix(0, 15);
    join_none
    repeat (12) @(posedge clk);
    #1;
    check("t3_f_ready_low", f_ready, 0);
    check("t3_pixel_held", f_valid && (f_data == 16'sd6), 1);
    check("t3_head_valid", o_valid, 1);
    check("t3_head_psum", o_psum, 32'd8);
    check("t3_head_idx", 32'(o_idx), 0);
    @(posedge clk); #1;
    check("t3_head_stable", o_psum, 32'd8);
    o_ready = 1'b1;
    @(negedge clk);
    check("t3_no_lookahead", f_ready, 0);
    @(posedge clk); #1;
    check("t3_f_ready_back", f_ready, 1);
    end_row();
    check("t3_out3", rx[3], 32'd26);
    check("t3_out13", rx[13], 32'd86);

    // Wrap-around: (-2^15)^2 * 3 = 3*2^30 mod 2^32
    wv = '{16'sh8000, 16'sh8000, 16'sh8000};
    for (int i = 0; i < 64; i++) fv[i] = 16'sh8000;
    begin_row(1'b0, 1'b0);
    send_pix(0, 15);
    end_row();
    check("t4_out0", rx[0], 32'hC000_0000);
    check("t4_out13", rx[13], 32'hC000_0000);

    // Asynchronous reset mid-stream, then a clean row
    set_ramp();
    begin_row(1'b0, 1'b0);
    send_pix(0, 7);
    #1 rstn = 1'b0;
    #1;
    check("t5_w_ready", w_ready, 0);
    check("t5_f_ready", f_ready, 0);
    check("t5_o_valid", o_valid, 0);
    check("t5_o_psum", o_psum, 0);
    check("t5_o_idx", 32'(o_idx), 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    exp_ps.delete();
    exp_ix.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    begin_row(1'b0, 1'b0);
    send_pix(0, 15);
    end_row();
    check("t5_out0", rx[0], 32'd8);
    check("t5_out13", rx[13], 32'd86);

    // start held during LOAD_W and pulsed during STREAM must be ignored
    begin_row(1'b0, 1'b1);
    check("t6_w_ready_low_in_stream", w_ready, 0);
    send_pix(0, 4);
    start = 1'b1;
    send_pix(5, 9);
    start = 1'b0;
    send_pix(10, 15);
    end_row();
    check("t6_out13", rx[13], 32'd86);
    check("t6_idle_after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end
endmodule
